pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage integer core. It merges stall requests from ID, EX and MEM, and runs a counter-based sequencer for multi-cycle EX operations such as multiply-accumulate and divide. It also issues a one-cycle pipeline flush with a redirect PC. Its `stall` vector drives the hold input of every pipeline register: pc, if/id, id/ex, ex/mem and mem/wb.

## Interface
- `STALL_W`, 6: stall vector width. Bit 0 = pc, 1 = if/id, 2 = id/ex, 3 = ex/mem, 4 = mem/wb, 5 = wb (reserved, always 0).
- `CNT_W`, 6: width of the multi-cycle length and counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_id`  in  1  ID needs a hold (load-use hazard); combinational.
- `stallreq_ex`  in  1  EX needs a hold for the current cycle only; combinational.
- `stallreq_mem`  in  1  MEM waiting on data memory; combinational.
- `mc_start`  in  1  EX begins a multi-cycle op; one-cycle pulse.
- `mc_cycles`  in  CNT_W  op length N in stall cycles; 0 is treated as 1.
- `flush_req`  in  1  exception or redirect request; one-cycle pulse.
- `flush_pc`  in  32  redirect target, sampled together with `flush_req`.
- `stall`  out  STALL_W  hold vector; combinational from state and requests.
- `flush`  out  1  registered; clears all pipeline registers for one cycle.
- `new_pc`  out  32  registered; redirect PC, valid while `flush` = 1.
- `mc_busy`  out  1  registered; high in MC_RUN.
- `mc_done`  out  1  registered; one-cycle pulse when the multi-cycle result may leave EX.

## Operation
- States: IDLE, MC_RUN, MC_DONE, FLUSH. Internal counter `cnt` is CNT_W bits.
- Stall patterns:
  - ID: 6'b000111
  - EX: 6'b001111
  - MEM: 6'b011111
  - none: 6'b000000
- Stall priority, highest first:
  1. FLUSH state forces 0.
  2. MEM pattern if `stallreq_mem`.
  3. EX pattern if `stallreq_ex`, or state = MC_RUN, or (state = IDLE and `mc_start`).
  4. ID pattern if `stallreq_id`.
  5. Otherwise 0.
- IDLE:
  - `flush_req` → FLUSH.
  - Otherwise, `mc_start` → MC_RUN, with `cnt` = max(N,1) − 1.
  - If `cnt` would load 0 (N ≤ 1), go to MC_DONE directly.
- MC_RUN:
  - Each cycle with `stallreq_mem` = 0: `cnt` decrements.
  - On the cycle `cnt` = 1 and decrementing → MC_DONE.
  - `stallreq_mem` = 1 freezes `cnt` and the state.
- MC_DONE:
  - `mc_done` = 1, EX stall released (subject to other requests), then → IDLE.
  - `mc_start` arriving in MC_DONE is ignored. EX must not issue back-to-back.
- FLUSH:
  - `flush` = 1 and `new_pc` = latched `flush_pc` for exactly one cycle, then → IDLE.
- `flush_req` in any state has top priority: next state is FLUSH and `flush_pc` is latched.
  - An in-progress MC_RUN is aborted. `mc_done` is never pulsed for the aborted op and `cnt` is cleared.
  - `flush_req` during FLUSH restarts FLUSH with the new PC, so `flush` stays high for one extra cycle.
- `mc_start` together with `flush_req`: the flush wins and the multi-cycle op is dropped.

## Timing
- Reset values: state IDLE, `cnt` 0, `stall` 0, `flush` 0, `new_pc` 32'h0, `mc_busy` 0, `mc_done` 0.
- `rst` asserted mid-operation returns everything to the reset values on the next edge, regardless of the current state.
- Multi-cycle latency with `mc_start` at cycle T0 and no MEM stalls:
  - EX stall asserted in cycles T0 … T0+N−1, N cycles total.
  - `mc_busy` high in T0+1 … T0+N−1.
  - `mc_done` high in T0+N, the same cycle the stall drops.
  - Each MEM-stalled cycle extends the sequence by one cycle.
- Flush latency: `flush_req` at T gives `flush` = 1 and `new_pc` valid at T+1; `stall` = 0 at T+1.
- `stall` reacts combinationally in the same cycle as `stallreq_*`. No registered delay on request pass-through.
- Bit 5 of `stall` is always 0.

## Test plan
- Stall priority, state IDLE: `stallreq_id`=1 alone → `stall`=6'b000111; add `stallreq_ex` → 6'b001111; add `stallreq_mem` → 6'b011111; drop all → 0 in the same cycle.
- `mc_start`, `mc_cycles`=4 at T0 → `stall`=6'b001111 in T0–T3, `mc_busy` high in T1–T3, `mc_done`=1 and `stall`=0 in T4, IDLE in T5.
- `mc_cycles`=0 and `mc_cycles`=1 → exactly one stall cycle, `mc_done` in the next cycle.
- `mc_cycles`=3 with `stallreq_mem`=1 for 2 cycles at T1 → `stall`=6'b011111 in those cycles; `mc_done` at T0+5.
- `flush_req`, `flush_pc`=32'h0000_0100 at T2 of a 10-cycle op → `flush`=1, `new_pc`=32'h100, `stall`=0 at T3; IDLE at T4; no `mc_done`.
- `rst` high during MC_RUN → next cycle all outputs 0, state IDLE; a subsequent `mc_start` with N=2 behaves normally.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall requests, sequences multi-cycle EX ops,
// and issues a one-cycle flush with a redirect PC.
module pipe_ctrl #(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               mc_start,
  input  logic [CNT_W-1:0]   mc_cycles,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               mc_busy,
  output logic               mc_done
);

  typedef enum logic [1:0] {StIdle, StMcRun, StMcDone, StFlush} state_e;

  // Hold patterns: each stage requester also holds everything upstream of it.
  localparam logic [STALL_W-1:0] StallId  = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] StallEx  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] StallMem = STALL_W'(6'b011111);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       pc_q, pc_d;

  // State, counter and redirect-PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic; flush_req overrides everything and aborts any multi-cycle op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (flush_req) begin
      state_d = StFlush;
      cnt_d   = '0;
      pc_d    = flush_pc;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mc_start) begin
            // Lengths 0 and 1 both give a single stall cycle
            if (mc_cycles <= CNT_W'(1)) begin
              state_d = StMcDone;
              cnt_d   = '0;
            end else begin
              state_d = StMcRun;
              cnt_d   = mc_cycles - CNT_W'(1);
            end
          end
        end
        StMcRun: begin
          // A MEM stall freezes the sequencer so the op length is counted in free cycles
          if (!stallreq_mem) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = StMcDone;
            end
          end
        end
        StMcDone: state_d = StIdle;
        StFlush:  state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Stall vector, combinational from state and the live requests
  always_comb begin
    stall = '0;
    if (state_q == StFlush) begin
      stall = '0;
    end else if (stallreq_mem) begin
      stall = StallMem;
    end else if (stallreq_ex || (state_q == StMcRun) || ((state_q == StIdle) && mc_start)) begin
      stall = StallEx;
    end else if (stallreq_id) begin
      stall = StallId;
    end
  end

  // Registered outputs decoded straight from the state register
  always_comb begin
    flush   = (state_q == StFlush);
    mc_busy = (state_q == StMcRun);
    mc_done = (state_q == StMcDone);
    new_pc  = pc_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes per-cycle expectations, a monitor checks them.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy, mc_done;

  typedef struct {
    int          step;
    logic [5:0]  stall;
    logic        flush;
    logic        pc_chk;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  pipe_ctrl #(.STALL_W(6), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .mc_start     (mc_start),
    .mc_cycles    (mc_cycles),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs just after the edge and queue the outputs expected in that cycle
  task automatic cyc(input logic r, input logic id, input logic ex, input logic mem,
                     input logic st, input logic [5:0] n, input logic fr, input logic [31:0] fpc,
                     input logic [5:0] e_stall, input logic e_flush, input logic e_pc_chk,
                     input logic [31:0] e_pc, input logic e_busy, input logic e_done);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    mc_start = st; mc_cycles = n; flush_req = fr; flush_pc = fpc;
    step_n++;
    e.step = step_n; e.stall = e_stall; e.flush = e_flush; e.pc_chk = e_pc_chk;
    e.pc = e_pc; e.busy = e_busy; e.done = e_done;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (stall !== e.stall) begin
          errors++;
          $display("FAIL stall step %0d: got %b want %b", e.step, stall, e.stall);
        end
        checks++;
        if (flush !== e.flush) begin
          errors++;
          $display("FAIL flush step %0d: got %b want %b", e.step, flush, e.flush);
        end
        checks++;
        if (mc_busy !== e.busy) begin
          errors++;
          $display("FAIL mc_busy step %0d: got %b want %b", e.step, mc_busy, e.busy);
        end
        checks++;
        if (mc_done !== e.done) begin
          errors++;
          $display("FAIL mc_done step %0d: got %b want %b", e.step, mc_done, e.done);
        end
        if (e.pc_chk) begin
          checks++;
          if (new_pc !== e.pc) begin
            errors++;
            $display("FAIL new_pc step %0d: got %h want %h", e.step, new_pc, e.pc);
          end
        end
      end
    end
  end

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;

  initial begin
    rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mc_start = 0; mc_cycles = '0; flush_req = 0; flush_pc = '0;

    //   rst id ex mem st n   fr fpc           stall fl pc? pc            busy done
    // Reset state
    cyc(1, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 1, 32'h0,        0, 0);
    // Stall priority in IDLE
    cyc(0, 1, 0, 0, 0, 0,  0, 32'h0,        SI, 0, 0, 32'h0,        0, 0);
    cyc(0, 1, 1, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 1, 1, 1, 0, 0,  0, 32'h0,        SM, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // N=4
    cyc(0, 0, 0, 0, 1, 4,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 1);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // N=0
    cyc(0, 0, 0, 0, 1, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 1);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // N=1, with an mc_start in MC_DONE that must be ignored
    cyc(0, 0, 0, 0, 1, 1,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 1, 4,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 1);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // N=3 with two MEM-stalled cycles at T1
    cyc(0, 0, 0, 0, 1, 3,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 1, 0, 0,  0, 32'h0,        SM, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 1, 0, 0,  0, 32'h0,        SM, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 1);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // Flush at T2 of a 10-cycle op; MEM request during FLUSH must not stall
    cyc(0, 0, 0, 0, 1, 10, 0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  1, 32'h100,      SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 1, 0, 0,  0, 32'h0,        S0, 1, 1, 32'h100,      0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // Back-to-back flush requests restart FLUSH with the new PC
    cyc(0, 0, 0, 0, 0, 0,  1, 32'h200,      S0, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  1, 32'h300,      S0, 1, 1, 32'h200,      0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 1, 1, 32'h300,      0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // mc_start with flush_req: flush wins, op dropped
    cyc(0, 0, 0, 0, 1, 5,  1, 32'h400,      SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 1, 1, 32'h400,      0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);
    // Reset during MC_RUN, then a normal N=2 op
    cyc(0, 0, 0, 0, 1, 8,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(1, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 1, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 1, 2,  0, 32'h0,        SE, 0, 0, 32'h0,        0, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        SE, 0, 0, 32'h0,        1, 0);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 1);
    cyc(0, 0, 0, 0, 0, 0,  0, 32'h0,        S0, 0, 0, 32'h0,        0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
